// File: rtl/frame_scheduler.sv
// frame_scheduler: sequences WS2812B frame transmission for the 8-LED strip.
// It captures a stable 96-bit GRB frame, pulses go to the serializer, waits
// for driverDone (or a timeout) and then holds the line idle for the latch gap.
// Frames come from a periodic refresh tick (when enabled) and from manual
// send requests. Requests that arrive while a frame is in flight collapse
// into a single pending frame.
module frame_scheduler #(
  parameter int LATCH_CYCLES   = 6000,
  parameter int REFRESH_CYCLES = 1666667,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        sendReq,
  input  logic [95:0] frameData,
  input  logic        driverReady,
  input  logic        driverDone,
  output logic        go,
  output logic [95:0] frameOut,
  output logic        busy,
  output logic [2:0]  step,
  output logic        timeoutErr
);

  // Refresh counter only needs to hold REFRESH_CYCLES-1.
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  // One counter is shared by the timeout wait and the latch gap, so size it
  // for whichever is longer.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > LATCH_CYCLES) ? TIMEOUT_CYCLES : LATCH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [REF_W-1:0] REF_LAST     = REF_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST   = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    LATCH     = 2'd3
  } stateType;

  stateType         state;
  logic [REF_W-1:0] refCnt;
  logic [CNT_W-1:0] cnt;
  logic             refPend;
  logic             manPend;

  logic tick;
  logic request;
  logic startEntry;

  // The tick is a pure decode of the free-running refresh counter.
  assign tick = (refCnt == REF_LAST);

  // A live request or a remembered one; the live terms let a request that
  // arrives while IDLE start the frame without first going through a flag.
  assign request = refPend | manPend | (tick & enable) | sendReq;

  // The single condition that launches a frame. Pending flags clear on this
  // same edge, which is how a coincident tick/sendReq is absorbed.
  assign startEntry = (state == IDLE) && request && driverReady;

  // Free-running refresh counter, 0..REFRESH_CYCLES-1, active in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      refCnt <= '0;
    end else if (tick) begin
      refCnt <= '0;
    end else begin
      refCnt <= refCnt + REF_W'(1);
    end
  end

  // Pending-request flags: remember refresh ticks and manual sends until the
  // next frame launch. Launch clears win over a set on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      refPend <= 1'b0;
      manPend <= 1'b0;
    end else begin
      if (!enable || startEntry) begin
        refPend <= 1'b0;
      end else if (tick) begin
        refPend <= 1'b1;
      end

      if (startEntry) begin
        manPend <= 1'b0;
      end else if (sendReq) begin
        manPend <= 1'b1;
      end
    end
  end

  // Frame sequencer with registered outputs: launch, wait for the serializer,
  // then hold the latch gap before accepting the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      go         <= 1'b0;
      frameOut   <= '0;
      busy       <= 1'b0;
      step       <= '0;
      timeoutErr <= 1'b0;
      cnt        <= '0;
    end else begin
      // go is a strobe; only the IDLE launch raises it for one cycle.
      go <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (startEntry) begin
            state    <= START;
            go       <= 1'b1;
            busy     <= 1'b1;
            frameOut <= frameData;
          end
        end

        // driverDone is deliberately ignored here: it cannot belong to the
        // frame that has only just been launched.
        START: begin
          state <= WAIT_DONE;
          cnt   <= '0;
        end

        WAIT_DONE: begin
          if (driverDone) begin
            state <= LATCH;
            step  <= step + 3'd1;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            // Give up on this frame; the animation step does not advance
            // because the strip never confirmed the frame.
            state      <= LATCH;
            timeoutErr <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        LATCH: begin
          if (cnt == LATCH_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scheduler.sv
// tb_frame_scheduler: directed checks of frame_scheduler with short latch,
// refresh and timeout periods (4 / 50 / 20 clocks).
module tb_frame_scheduler;

  localparam int LATCH   = 4;
  localparam int REFRESH = 50;
  localparam int TIMEOUT = 20;

  localparam logic [95:0] FRAME_A = 96'hBEEDAD_0123_4567_89AB_CDEF_01;
  localparam logic [95:0] FRAME_B = 96'hCABFAD_FEDC_BA98_7654_3210_AA;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        sendReq;
  logic [95:0] frameData;
  logic        driverReady;
  logic        driverDone;
  logic        go;
  logic [95:0] frameOut;
  logic        busy;
  logic [2:0]  step;
  logic        timeoutErr;

  int checkCnt = 0;
  int passCnt  = 0;
  int goBusyViol = 0;
  logic prevBusy;

  // Bench-side refresh phase: mirrors when the refresh tick should occur.
  int ph;

  frame_scheduler #(
    .LATCH_CYCLES   (LATCH),
    .REFRESH_CYCLES (REFRESH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sendReq     (sendReq),
    .frameData   (frameData),
    .driverReady (driverReady),
    .driverDone  (driverDone),
    .go          (go),
    .frameOut    (frameOut),
    .busy        (busy),
    .step        (step),
    .timeoutErr  (timeoutErr)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Expected refresh phase: tick is due whenever ph == REFRESH-1.
  always @(posedge clk) begin
    if (reset) ph <= 0;
    else ph <= (ph == REFRESH - 1) ? 0 : ph + 1;
  end

  task automatic checkVal(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checkCnt++;
    if (got === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n clocks; sample point is 1 ns after each rising edge.
  task automatic stepClk(input int n);
    for (int k = 0; k < n; k++) begin
      prevBusy = busy;
      @(posedge clk);
      #1;
      if (go === 1'b1 && prevBusy === 1'b1) goBusyViol++;
    end
  endtask

  initial begin
    int gos;
    int doneAt;
    int firstGoAt;
    int lastGoAt;
    logic [95:0] lastFrame;

    reset = 1'b1; enable = 1'b0; sendReq = 1'b0; frameData = '0;
    driverReady = 1'b1; driverDone = 1'b0;

    // ---- Reset ----
    stepClk(3);
    checkVal("rst_go", 96'(go), 96'd0);
    checkVal("rst_busy", 96'(busy), 96'd0);
    checkVal("rst_step", 96'(step), 96'd0);
    checkVal("rst_frameOut", frameOut, 96'd0);
    checkVal("rst_timeoutErr", 96'(timeoutErr), 96'd0);
    reset = 1'b0;
    stepClk(2);
    $display("txn reset: outputs idle");

    // ---- Manual send ----
    frameData = FRAME_A; sendReq = 1'b1;
    stepClk(1); sendReq = 1'b0;                 // go cycle g
    checkVal("man_go", 96'(go), 96'd1);
    checkVal("man_frameOut", frameOut, FRAME_A);
    checkVal("man_busy_rise", 96'(busy), 96'd1);
    stepClk(1);                                  // g+1
    checkVal("man_go_width", 96'(go), 96'd0);
    stepClk(9);                                  // g+10
    driverDone = 1'b1;
    checkVal("man_step_before", 96'(step), 96'd0);
    stepClk(1); driverDone = 1'b0;               // g+11
    checkVal("man_step_after", 96'(step), 96'd1);
    stepClk(3);                                  // g+14, last latch cycle
    checkVal("man_busy_latch", 96'(busy), 96'd1);
    stepClk(1);                                  // g+15
    checkVal("man_busy_fall", 96'(busy), 96'd0);
    $display("txn manual: frame %h sent, step=%0d", frameOut, step);

    // ---- Auto-refresh with coincident sendReq ----
    reset = 1'b1; stepClk(3); reset = 1'b0;
    stepClk(1);
    for (int w = 0; w < 2 * REFRESH && ph != REFRESH - 1; w++) stepClk(1);
    checkVal("auto_tick_align", 96'(ph), 96'(REFRESH - 1));
    enable = 1'b1; sendReq = 1'b1;               // tick cycle t0
    gos = 0; doneAt = -1; firstGoAt = -1;
    for (int i = 1; i <= 199; i++) begin
      stepClk(1);
      sendReq = 1'b0;
      if (go === 1'b1) begin
        gos++;
        if (firstGoAt < 0) firstGoAt = i;
        doneAt = i + 10;
      end
      driverDone = (i == doneAt);
      if (i == 199) enable = 1'b0;
    end
    driverDone = 1'b0;
    checkVal("auto_first_go", 96'(firstGoAt), 96'd1);
    checkVal("auto_go_count", 96'(gos), 96'd4);
    checkVal("auto_step", 96'(step), 96'd4);
    $display("txn auto: %0d frames, step=%0d", gos, step);

    // ---- Busy queuing ----
    frameData = FRAME_A; sendReq = 1'b1;
    stepClk(1); sendReq = 1'b0;                  // go cycle g
    checkVal("q_go1", 96'(go), 96'd1);
    gos = 0; lastGoAt = -1; lastFrame = '0;
    for (int i = 1; i <= 40; i++) begin
      stepClk(1);
      if (go === 1'b1) begin
        gos++;
        lastGoAt = i;
        lastFrame = frameOut;
      end
      if (i == 8) checkVal("q_frame_hold", frameOut, FRAME_A);
      frameData  = (i >= 2) ? FRAME_B : FRAME_A;
      sendReq    = (i == 3 || i == 5 || i == 7);
      driverDone = (i == 10 || i == 26);
    end
    sendReq = 1'b0; driverDone = 1'b0;
    checkVal("q_go_count", 96'(gos), 96'd1);
    checkVal("q_go_time", 96'(lastGoAt), 96'd16);
    checkVal("q_frameOut", lastFrame, FRAME_B);
    checkVal("q_step", 96'(step), 96'd6);
    $display("txn queue: extra frame %h at +%0d", lastFrame, lastGoAt);

    // ---- Timeout ----
    sendReq = 1'b1;
    stepClk(1); sendReq = 1'b0;                  // go cycle g
    for (int i = 1; i <= 30; i++) begin
      stepClk(1);
      if (i == 20) checkVal("to_err_before", 96'(timeoutErr), 96'd0);
      if (i == 21) checkVal("to_err_set", 96'(timeoutErr), 96'd1);
      if (i == 24) checkVal("to_busy_latch", 96'(busy), 96'd1);
      if (i == 25) checkVal("to_busy_fall", 96'(busy), 96'd0);
    end
    checkVal("to_step", 96'(step), 96'd6);
    checkVal("to_err_sticky", 96'(timeoutErr), 96'd1);
    $display("txn timeout: timeoutErr=%0d step=%0d", timeoutErr, step);

    // ---- Reset mid-frame ----
    frameData = FRAME_A; sendReq = 1'b1;
    stepClk(1); sendReq = 1'b0;                  // go cycle g
    checkVal("mid_go", 96'(go), 96'd1);
    stepClk(3);                                  // g+3, WAIT_DONE
    reset = 1'b1;
    stepClk(1); reset = 1'b0;
    checkVal("mid_busy", 96'(busy), 96'd0);
    checkVal("mid_go_clear", 96'(go), 96'd0);
    checkVal("mid_step", 96'(step), 96'd0);
    checkVal("mid_frameOut", frameOut, 96'd0);
    checkVal("mid_timeoutErr", 96'(timeoutErr), 96'd0);
    gos = 0;
    for (int i = 0; i < 6; i++) begin
      stepClk(1);
      if (go === 1'b1) gos++;
    end
    checkVal("mid_no_reissue", 96'(gos), 96'd0);
    $display("txn midreset: frame abandoned");

    // ---- driverReady gating ----
    driverReady = 1'b0; frameData = FRAME_B; sendReq = 1'b1;
    stepClk(1); sendReq = 1'b0;
    gos = 0;
    for (int i = 0; i < 8; i++) begin
      if (go === 1'b1) gos++;
      stepClk(1);
    end
    if (go === 1'b1) gos++;
    checkVal("gate_no_go", 96'(gos), 96'd0);
    checkVal("gate_idle", 96'(busy), 96'd0);
    driverReady = 1'b1;
    stepClk(1);
    checkVal("gate_go", 96'(go), 96'd1);
    checkVal("gate_frameOut", frameOut, FRAME_B);
    $display("txn gating: frame %h sent after driverReady", frameOut);

    checkVal("go_while_busy", 96'(goBusyViol), 96'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/frame_scheduler.md
# frame_scheduler

Sequences frame transmission from the mode machine's 96-bit register value (8 LEDs × 12-bit GRB, 4 bits per colour) to the WS2812B serializer on the BASYS 3. It captures a stable frame and issues a one-cycle `go` to the serializer. It then waits for completion and enforces the WS2812B latch/reset gap. Frames are issued on a periodic refresh tick and on manual send requests, and a 3-bit animation step advances after each completed frame for the pattern generators.

## Interface
- `LATCH_CYCLES`, default 6000: idle low-time after each frame (60 µs at 100 MHz); must be ≥1.
- `REFRESH_CYCLES`, default 1666667: refresh tick period in clocks (60 Hz); must be ≥2.
- `TIMEOUT_CYCLES`, default 32768: maximum wait for `driverDone` after `go`; must be ≥1.
- `clk`  in  1  system clock, 100 MHz, rising edge.
- `reset`  in  1  synchronous, active-high; clears all state on the clock edge where it is sampled high.
- `enable`  in  1  auto-refresh enable.
- `sendReq`  in  1  manual frame request, level-sampled each cycle.
- `frameData`  in  96  frame from the mode machine (its `regVal`).
- `driverReady`  in  1  serializer idle and able to accept `go`.
- `driverDone`  in  1  one-cycle pulse from the serializer after the last bit.
- `go`  out  1  one-cycle start pulse to the serializer.
- `frameOut`  out  96  latched frame, held stable from `go` until the next capture.
- `busy`  out  1  high in every state except IDLE.
- `step`  out  3  animation step, wraps 7→0.
- `timeoutErr`  out  1  sticky; set when a frame times out.

## Operation
- States: IDLE, START, WAIT_DONE, LATCH. All outputs are registered.
- Reset values: state IDLE, `go`=0, `frameOut`=0, `busy`=0, `step`=0, `timeoutErr`=0. The refresh counter, timeout/latch counter and both pending flags are 0.
- Refresh counter: free-running from 0 to REFRESH_CYCLES−1, then wraps. The tick is asserted in the cycle the counter equals REFRESH_CYCLES−1. It runs in all states.
- Pending flags:
  - `refPend` is set by the tick when `enable`=1. It is cleared when `enable`=0 or on entry to START.
  - `manPend` is set by `sendReq`=1 and cleared on entry to START. It is unaffected by `enable`.
- A request is `refPend | manPend | (tick & enable) | sendReq`. Multiple requests arriving while busy collapse into one pending frame.
- IDLE→START: taken when a request is present and `driverReady`=1. On that edge `frameOut` ← `frameData`, `go` ← 1, and both pending flags are cleared. Requests stay pending while `driverReady`=0.
- START→WAIT_DONE: unconditional after 1 cycle; `go` returns to 0. `driverDone` seen in START is ignored.
- WAIT_DONE:
  - If `driverDone`=1, go to LATCH and increment `step` (mod 8).
  - If the counter reaches TIMEOUT_CYCLES without `driverDone`, set `timeoutErr`, go to LATCH, and leave `step` unchanged.
- LATCH: counts LATCH_CYCLES cycles, then returns to IDLE. Requests arriving during LATCH are pending only and are served from IDLE afterwards.
- `sendReq` or `tick` arriving on the same edge as a START entry is consumed by that frame. It does not create a second frame.
- Reset mid-frame: returns to IDLE with all reset values on the next edge. The in-flight frame is abandoned and no `go` is reissued.

## Timing
- Request latency: with IDLE and `driverReady`=1, a request sampled at edge n gives `go`=1 and the new `frameOut` in cycle n+1.
- `go` width is exactly 1 cycle per frame. `go` is never asserted while `busy` was already high.
- `busy` rises with `go`. It falls exactly LATCH_CYCLES cycles after the edge at which WAIT_DONE exits.
- `step` updates on the edge that samples `driverDone` in WAIT_DONE.
- Minimum frame-to-frame spacing is 1 (START) + wait + LATCH_CYCLES + 1 (IDLE) cycles.
- The timeout counter is 0 at entry to WAIT_DONE and is reused for the LATCH count.

## Test plan
Run with LATCH_CYCLES=4, REFRESH_CYCLES=50, TIMEOUT_CYCLES=20.
- **Reset:** `reset`=1 for 3 cycles → `go`=0, `busy`=0, `step`=0, `frameOut`=0, `timeoutErr`=0.
- **Manual send:** `enable`=0, `driverReady`=1, `frameData`=96'hBEEDAD…, 1-cycle `sendReq`, `driverDone` 10 cycles after `go`.
  - `go` is a single pulse in the cycle after `sendReq`, and `frameOut`=BEEDAD….
  - `step`=1.
  - `busy` falls 4 cycles after `driverDone`.
- **Auto-refresh and coalescing:** `enable`=1, plus `sendReq` on the same cycle as a tick → exactly one `go` per tick over 200 cycles (4 frames), and `step` advances to 4.
- **Busy queuing:** three `sendReq` pulses during WAIT_DONE with `frameData` changed to CABFAD… → exactly one further `go`, issued after LATCH, with `frameOut`=CABFAD….
- **Timeout:** `driverDone` is never pulsed → `timeoutErr`=1 twenty cycles after `go`, `step` unchanged, and IDLE is reached 4 cycles later. `timeoutErr` stays 1 until `reset`.
- **Reset mid-frame and driverReady gating:**
  - `reset` in WAIT_DONE → IDLE next cycle with no `go`.
  - `driverReady`=0 with a pending request → no `go` until `driverReady`=1, then `go` in the following cycle.
